// File: rtl/gmii_tx_framer.sv
// gmii_tx_framer: frames an AXI-Stream byte stream onto GMII TX.
// Define GMII_TX_FCS_EN to append the CRC-32 FCS in hardware.
module gmii_tx_framer #(
    parameter int MIN_FRAME = 60,
    parameter int IFG_BYTES = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_tdata,
    input  logic       s_tvalid,
    input  logic       s_tlast,
    output logic       s_tready,
    output logic [7:0] txd,
    output logic       tx_en,
    output logic       tx_er,
    output logic       frame_done,
    output logic       underrun
);

    localparam logic [15:0] MIN_LEN  = 16'(MIN_FRAME);
    localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);

    typedef enum logic [3:0] {
        IDLE,
        PRE,
        SFD,
        DATA,
        PAD,
`ifdef GMII_TX_FCS_EN
        FCS,
`endif
        ERR,
        DISCARD,
        IFG
    } state_t;

    state_t      state, state_n;
    logic [7:0]  txd_n;
    logic        tx_en_n, tx_er_n;
    logic        done_n, urun_n;
    logic [2:0]  pre_cnt, pre_n;
    logic [7:0]  ifg_cnt, ifg_n;
    logic [15:0] byte_cnt, cnt_n, cnt_inc;
    logic        last_seen, last_n;

`ifdef GMII_TX_FCS_EN
    logic [1:0]  fcs_cnt, fcs_n;
    logic [31:0] crc, crc_n, crc_inv;

    function automatic logic [31:0] crc_byte(
        input logic [31:0] c,
        input logic [7:0]  d
    );
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    assign crc_inv = ~crc;
`endif

    assign cnt_inc = (byte_cnt == 16'hFFFF) ? byte_cnt
                                            : byte_cnt + 16'd1;

    // Ready while a frame byte can be taken or is being drained
    assign s_tready = (state == SFD) ||
                      ((state == DATA || state == DISCARD) &&
                       !last_seen);

    // Next state plus the GMII byte that state will carry
    always_comb begin
        state_n = state;
        txd_n   = 8'h00;
        tx_en_n = 1'b0;
        tx_er_n = 1'b0;
        done_n  = 1'b0;
        urun_n  = 1'b0;
        pre_n   = pre_cnt;
        ifg_n   = ifg_cnt;
        cnt_n   = byte_cnt;
        last_n  = last_seen;
`ifdef GMII_TX_FCS_EN
        fcs_n   = fcs_cnt;
        crc_n   = crc;
`endif
        unique case (state)
            IDLE: begin
                if (s_tvalid) begin
                    state_n = PRE;
                    txd_n   = 8'h55;
                    tx_en_n = 1'b1;
                    pre_n   = 3'd0;
                end
            end
            PRE: begin
                tx_en_n = 1'b1;
                cnt_n   = 16'd0;
                last_n  = 1'b0;
`ifdef GMII_TX_FCS_EN
                crc_n   = 32'hFFFFFFFF;
`endif
                if (pre_cnt == 3'd6) begin
                    state_n = SFD;
                    txd_n   = 8'hD5;
                end else begin
                    txd_n = 8'h55;
                    pre_n = pre_cnt + 3'd1;
                end
            end
            SFD, DATA, PAD: begin
                if (state != PAD && !last_seen) begin
                    tx_en_n = 1'b1;
                    if (s_tvalid) begin
                        state_n = DATA;
                        txd_n   = s_tdata;
                        cnt_n   = cnt_inc;
                        last_n  = s_tlast;
`ifdef GMII_TX_FCS_EN
                        crc_n   = crc_byte(crc, s_tdata);
`endif
                    end else begin
                        state_n = ERR;
                        tx_er_n = 1'b1;
                        urun_n  = 1'b1;
                    end
                end else if (byte_cnt < MIN_LEN) begin
                    state_n = PAD;
                    tx_en_n = 1'b1;
                    cnt_n   = cnt_inc;
`ifdef GMII_TX_FCS_EN
                    crc_n   = crc_byte(crc, 8'h00);
`endif
                end else begin
`ifdef GMII_TX_FCS_EN
                    state_n = FCS;
                    txd_n   = crc_inv[7:0];
                    tx_en_n = 1'b1;
                    fcs_n   = 2'd0;
`else
                    state_n = IFG;
                    done_n  = 1'b1;
                    ifg_n   = 8'd0;
`endif
                end
            end
`ifdef GMII_TX_FCS_EN
            FCS: begin
                if (fcs_cnt == 2'd3) begin
                    state_n = IFG;
                    done_n  = 1'b1;
                    ifg_n   = 8'd0;
                end else begin
                    tx_en_n = 1'b1;
                    txd_n   = crc_inv[{fcs_cnt + 2'd1, 3'b000} +: 8];
                    fcs_n   = fcs_cnt + 2'd1;
                end
            end
`endif
            ERR: begin
                state_n = last_seen ? IFG : DISCARD;
                ifg_n   = 8'd0;
            end
            DISCARD: begin
                if (s_tvalid && s_tlast) begin
                    state_n = IFG;
                    ifg_n   = 8'd0;
                end
            end
            IFG: begin
                if (ifg_cnt == IFG_LAST) begin
                    if (s_tvalid) begin
                        state_n = PRE;
                        txd_n   = 8'h55;
                        tx_en_n = 1'b1;
                        pre_n   = 3'd0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    ifg_n = ifg_cnt + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, counters and registered GMII outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            txd        <= 8'h00;
            tx_en      <= 1'b0;
            tx_er      <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
            pre_cnt    <= 3'd0;
            ifg_cnt    <= 8'd0;
            byte_cnt   <= 16'd0;
            last_seen  <= 1'b0;
`ifdef GMII_TX_FCS_EN
            fcs_cnt    <= 2'd0;
            crc        <= 32'd0;
`endif
        end else begin
            state      <= state_n;
            txd        <= txd_n;
            tx_en      <= tx_en_n;
            tx_er      <= tx_er_n;
            frame_done <= done_n;
            underrun   <= urun_n;
            pre_cnt    <= pre_n;
            ifg_cnt    <= ifg_n;
            byte_cnt   <= cnt_n;
            last_seen  <= last_n;
`ifdef GMII_TX_FCS_EN
            fcs_cnt    <= fcs_n;
            crc        <= crc_n;
`endif
        end
    end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// tb_gmii_tx_framer: directed bench for gmii_tx_framer.
// Follows GMII_TX_FCS_EN the same way the design does.
module tb_gmii_tx_framer;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel;
    logic [7:0] tdata;
    logic       tvalid, tlast;

    logic [7:0] txd9, txd60, txd;
    logic       rdy9, en9, er9, done9, ur9;
    logic       rdy60, en60, er60, done60, ur60;
    logic       rdy, en, er, done, ur;

    int nerr, nchk, accepted;

    logic [7:0] stim_d[$];
    bit         stim_l[$];
    logic [7:0] exp_q[$];
    int         exp_len[$];
    logic [7:0] tr_txd[$];
    bit         tr_en[$], tr_er[$], tr_done[$], tr_ur[$];
    int         bs[$], be[$];

    typedef struct packed {
        logic       v;
        logic [7:0] d;
        logic       l;
        logic       rdy;
        logic [7:0] txd;
        logic       en;
        logic       er;
        logic       done;
    } vec_t;

    vec_t tbl[$];

`ifdef GMII_TX_FCS_EN
    localparam int FCS_N = 4;
`else
    localparam int FCS_N = 0;
`endif

    always #4 clk = ~clk;

    gmii_tx_framer #(.MIN_FRAME(9), .IFG_BYTES(12)) dut9 (
        .clk(clk), .rst(rst),
        .s_tdata(tdata), .s_tvalid(tvalid & ~sel),
        .s_tlast(tlast), .s_tready(rdy9),
        .txd(txd9), .tx_en(en9), .tx_er(er9),
        .frame_done(done9), .underrun(ur9)
    );

    gmii_tx_framer dut60 (
        .clk(clk), .rst(rst),
        .s_tdata(tdata), .s_tvalid(tvalid & sel),
        .s_tlast(tlast), .s_tready(rdy60),
        .txd(txd60), .tx_en(en60), .tx_er(er60),
        .frame_done(done60), .underrun(ur60)
    );

    assign txd  = sel ? txd60  : txd9;
    assign rdy  = sel ? rdy60  : rdy9;
    assign en   = sel ? en60   : en9;
    assign er   = sel ? er60   : er9;
    assign done = sel ? done60 : done9;
    assign ur   = sel ? ur60   : ur9;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm,
                         input logic [31:0] got,
                         input logic [31:0] want);
        nchk++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    function automatic vec_t mk(logic v, logic [7:0] d, logic l,
                                logic r, logic [7:0] t, logic e,
                                logic x, logic dn);
        vec_t m;
        m = '{v, d, l, r, t, e, x, dn};
        return m;
    endfunction

`ifdef GMII_TX_FCS_EN
    function automatic logic [31:0] crc8(input logic [31:0] c,
                                         input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction
`endif

    task automatic build_exp(input int first, input int n,
                             input int minf);
        int tot;
`ifdef GMII_TX_FCS_EN
        logic [31:0] c;
        c = 32'hFFFFFFFF;
`endif
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(stim_d[first+i]);
`ifdef GMII_TX_FCS_EN
            c = crc8(c, stim_d[first+i]);
`endif
        end
        for (int i = n; i < minf; i++) begin
            exp_q.push_back(8'h00);
`ifdef GMII_TX_FCS_EN
            c = crc8(c, 8'h00);
`endif
        end
        tot = 8 + ((n > minf) ? n : minf);
`ifdef GMII_TX_FCS_EN
        c = ~c;
        for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
        tot += 4;
`endif
        exp_len.push_back(tot);
    endtask

    task automatic clear_all();
        stim_d.delete();
        stim_l.delete();
        exp_q.delete();
        exp_len.delete();
    endtask

    task automatic run(input int hole, input int ncyc);
        int  idx;
        bit  used;
        logic pv, pr;
        idx = 0; used = 0; pv = 0; pr = 0;
        tr_txd.delete(); tr_en.delete(); tr_er.delete();
        tr_done.delete(); tr_ur.delete();
        for (int c = 0; c < ncyc; c++) begin
            if (pv && pr) idx++;
            tr_txd.push_back(txd);
            tr_en.push_back(en);
            tr_er.push_back(er);
            tr_done.push_back(done);
            tr_ur.push_back(ur);
            pr = rdy;
            if (idx < stim_d.size()) begin
                if (idx == hole && !used && rdy) begin
                    tvalid = 1'b0;
                    used = 1;
                end else begin
                    tvalid = 1'b1;
                    tdata  = stim_d[idx];
                    tlast  = stim_l[idx];
                end
            end else begin
                tvalid = 1'b0;
                tlast  = 1'b0;
            end
            pv = tvalid;
            step();
        end
        if (pv && pr) idx++;
        tvalid = 1'b0;
        tlast  = 1'b0;
        accepted = idx;
    endtask

    task automatic check_trace(input string tag, input int ndone,
                               input int nur, input int ner);
        int off, bad, sd, su, se;
        bit inb;
        bs.delete(); be.delete();
        inb = 0;
        for (int i = 0; i < tr_en.size(); i++) begin
            if (tr_en[i] && !inb) begin bs.push_back(i); inb = 1; end
            if (!tr_en[i] && inb) begin be.push_back(i-1); inb = 0; end
        end
        if (inb) be.push_back(tr_en.size() - 1);
        check({tag, "_bursts"}, bs.size(), exp_len.size());
        off = 0;
        for (int b = 0; b < bs.size() && b < exp_len.size(); b++) begin
            check($sformatf("%s_len%0d", tag, b),
                  be[b] - bs[b] + 1, exp_len[b]);
            bad = 0;
            for (int k = 0; k < exp_len[b] && k <= be[b] - bs[b]; k++)
                if (tr_txd[bs[b]+k] !== exp_q[off+k]) bad++;
            check($sformatf("%s_data%0d", tag, b), bad, 0);
            off += exp_len[b];
        end
        sd = 0; su = 0; se = 0;
        for (int i = 0; i < tr_en.size(); i++) begin
            sd += int'(tr_done[i]);
            su += int'(tr_ur[i]);
            se += int'(tr_er[i]);
        end
        check({tag, "_done"}, sd, ndone);
        check({tag, "_underrun"}, su, nur);
        check({tag, "_txer"}, se, ner);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] fcs_b [4];
        int         ntot;
        fcs_b = '{8'h26, 8'h39, 8'hF4, 8'hCB};
        nerr = 0; nchk = 0;
        rst = 1'b1; sel = 1'b0;
        tvalid = 1'b0; tlast = 1'b0; tdata = 8'h00;

        tbl.push_back(mk(1, 8'h31, 0, 0, 8'h00, 0, 0, 0));
        for (int i = 0; i < 7; i++)
            tbl.push_back(mk(1, 8'h31, 0, 0, 8'h55, 1, 0, 0));
        tbl.push_back(mk(1, 8'h31, 0, 1, 8'hD5, 1, 0, 0));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1, 8'(8'h32 + i), (i == 7), 1,
                             8'(8'h31 + i), 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 8'h39, 1, 0, 0));
        for (int i = 0; i < FCS_N; i++)
            tbl.push_back(mk(0, 8'h00, 0, 0, fcs_b[i], 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 1));
        for (int i = 0; i < 12; i++)
            tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0));

        repeat (3) step();
        check("reset", {rdy, txd, en, er, done, ur}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            check($sformatf("vec%0d", i),
                  {rdy, txd, en, er, done, ur},
                  {tbl[i].rdy, tbl[i].txd, tbl[i].en,
                   tbl[i].er, tbl[i].done, 1'b0});
            tvalid = tbl[i].v;
            tdata  = tbl[i].d;
            tlast  = tbl[i].l;
            step();
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
        sel = 1'b1;

        clear_all();
        stim_d.push_back(8'hAB); stim_l.push_back(1);
        build_exp(0, 1, 60);
        run(-1, 110);
        check("A_accept", accepted, 1);
        check_trace("A", 1, 0, 0);
        ntot = 0;
        foreach (tr_en[i]) ntot += int'(tr_en[i]);
        check("A_en_cycles", ntot, 68 + FCS_N);

        clear_all();
        for (int i = 0; i < 1514; i++) begin
            stim_d.push_back(8'(i * 7 + 3));
            stim_l.push_back(i == 1513);
        end
        for (int i = 0; i < 64; i++) begin
            stim_d.push_back(8'(i + 8'h40));
            stim_l.push_back(i == 63);
        end
        build_exp(0, 1514, 60);
        build_exp(1514, 64, 60);
        run(-1, 1700);
        check("B_accept", accepted, 1578);
        check_trace("B", 2, 0, 0);
        if (bs.size() >= 2 && be.size() >= 2) begin
            check("B_gap", bs[1] - be[0] - 1, 12);
            check("B_len64", be[1] - bs[1] + 1, 72 + FCS_N);
        end

        clear_all();
        for (int i = 0; i < 20; i++) begin
            stim_d.push_back(8'(8'hA0 + i));
            stim_l.push_back(i == 19);
        end
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < 5; i++) exp_q.push_back(8'(8'hA0 + i));
        exp_q.push_back(8'h00);
        exp_len.push_back(14);
        run(5, 60);
        check("C_accept", accepted, 20);
        check_trace("C", 0, 1, 1);
        if (be.size() >= 1) check("C_er_last", tr_er[be[0]], 1);

        clear_all();
        stim_d.push_back(8'hAB); stim_l.push_back(1);
        run(-1, 30);
        check("D_in_pad", {tr_en[29], tr_txd[29]}, {1'b1, 8'h00});
        rst = 1'b1;
        step();
        check("D_reset", {rdy, txd, en, er, done, ur}, 32'd0);
        rst = 1'b0;
        clear_all();
        for (int i = 0; i < 5; i++) begin
            stim_d.push_back(8'(8'h10 + i));
            stim_l.push_back(i == 4);
        end
        build_exp(0, 5, 60);
        run(-1, 110);
        check("D_accept", accepted, 5);
        check_trace("D", 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
